alu_sort_sequencer: RTL and testbench



---
 rtl/alu_sort_pkg.sv | 27 ++
 rtl/sort_reg_bank.sv | 41 ++++
 rtl/alu_sort_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_alu_sort_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sort_pkg.sv
// Shared definitions for the ALU-driven bubble sort sequencer.
//   - ALU select codes the sequencer issues to the neighbouring ALU
//   - FSM state encoding
//   - borrow reconstruction from the MSBs of A, B and A-B (the ALU flag
//     outputs are not used, so the sequencer derives A<B itself)
package alu_sort_pkg;

    localparam logic [2:0] ALU_PASS_A = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_PASS_B = 3'b101;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_CMP      = 3'd1;
    localparam state_t S_SWAP_HI  = 3'd2;
    localparam state_t S_SWAP_LO  = 3'd3;
    localparam state_t S_PASS_END = 3'd4;
    localparam state_t S_DONE     = 3'd5;

    // Borrow out of an unsigned subtraction R = A - B, recovered from MSBs.
    function automatic logic sub_borrow(input logic a_msb, input logic b_msb,
                                        input logic r_msb);
        return (~a_msb & b_msb) | (~(a_msb ^ b_msb) & r_msb);
    endfunction

endpackage

// File: rtl/sort_reg_bank.sv
// Register bank holding the words being sorted.
//   clk, rst_n         : clock, synchronous active-low clear of every entry
//   we, waddr, wdata   : single synchronous write port
//   raddr_a / rdata_a  : asynchronous read (pair low index j)
//   raddr_b / rdata_b  : asynchronous read (pair high index j+1)
//   raddr_c / rdata_c  : asynchronous read (host read port)
module sort_reg_bank #(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 8,
    parameter int ADDRWIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDRWIDTH-1:0] waddr,
    input  logic [DATAWIDTH-1:0] wdata,
    input  logic [ADDRWIDTH-1:0] raddr_a,
    input  logic [ADDRWIDTH-1:0] raddr_b,
    input  logic [ADDRWIDTH-1:0] raddr_c,
    output logic [DATAWIDTH-1:0] rdata_a,
    output logic [DATAWIDTH-1:0] rdata_b,
    output logic [DATAWIDTH-1:0] rdata_c
);

    logic [DATAWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
    assign rdata_c = mem[raddr_c];

endmodule

// File: rtl/alu_sort_sequencer.sv
// Ascending unsigned bubble sort (early exit) over a small bank, using an
// external combinational ALU for both the compare and the data moves.
//   clk, rst_n                         : clock, synchronous active-low reset
//   sLoadValid/sLoadData/sLoadReady    : append a word in IDLE
//   sClear                             : in IDLE, empty the bank (count <- 0)
//   sStart, sBusy, sDone               : start request, busy, completion pulse
//   sSwapCount                         : swaps in last sort (saturating)
//   sReadAddr/sReadData                : asynchronous host read of the bank
//   sAluA, sAluB, sSelAlu, sAluResult  : drive/return of the external ALU
//   dbg_state                          : current FSM state for observation
// Handshake: a load word is accepted on any rising edge where sLoadValid and
// sLoadReady are both high; sLoadValid may be held, data must be stable.
module alu_sort_sequencer
    import alu_sort_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int SELECTION = 3,
    parameter int DEPTH     = 8,
    parameter int ADDRWIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sLoadValid,
    input  logic [DATAWIDTH-1:0] sLoadData,
    output logic                 sLoadReady,
    input  logic                 sClear,
    input  logic                 sStart,
    output logic                 sBusy,
    output logic                 sDone,
    output logic [7:0]           sSwapCount,
    input  logic [ADDRWIDTH-1:0] sReadAddr,
    output logic [DATAWIDTH-1:0] sReadData,
    output logic [DATAWIDTH-1:0] sAluA,
    output logic [DATAWIDTH-1:0] sAluB,
    output logic [SELECTION-1:0] sSelAlu,
    input  logic [DATAWIDTH-1:0] sAluResult,
    output logic [2:0]           dbg_state
);

    localparam logic [ADDRWIDTH:0]   FULL     = (ADDRWIDTH+1)'(DEPTH);
    localparam logic [ADDRWIDTH-1:0] LIM_INIT = ADDRWIDTH'(DEPTH - 1);
    localparam logic [ADDRWIDTH-1:0] LIM_LAST = ADDRWIDTH'(1);

    state_t               state, state_next;
    logic [ADDRWIDTH-1:0] j, j_inc, lim;
    logic [ADDRWIDTH:0]   count;
    logic                 swapped;
    logic [DATAWIDTH-1:0] tmp;
    logic [DATAWIDTH-1:0] bank_j, bank_j1;
    logic                 gt, last_pair, load_fire, start_ok, sort_finished;
    logic                 bank_we;
    logic [ADDRWIDTH-1:0] bank_waddr;
    logic [DATAWIDTH-1:0] bank_wdata;

    assign j_inc     = j + 1'b1;
    assign last_pair = (j_inc == lim);
    // A > B exactly when A-B is non-zero and did not borrow; equal never swaps.
    assign gt = (sAluResult != '0) &&
                !sub_borrow(sAluA[DATAWIDTH-1], sAluB[DATAWIDTH-1],
                            sAluResult[DATAWIDTH-1]);

    assign sLoadReady    = (state == S_IDLE) && (count < FULL);
    // sClear wins over both a same-cycle load and a same-cycle start.
    assign load_fire     = sLoadValid && sLoadReady && !sClear;
    assign start_ok      = (state == S_IDLE) && sStart && !sClear && (count == FULL);
    assign sort_finished = !swapped || (lim == LIM_LAST);
    assign dbg_state     = state;

    sort_reg_bank #(
        .DATAWIDTH(DATAWIDTH), .DEPTH(DEPTH), .ADDRWIDTH(ADDRWIDTH)
    ) u_bank (
        .clk(clk), .rst_n(rst_n),
        .we(bank_we), .waddr(bank_waddr), .wdata(bank_wdata),
        .raddr_a(j), .raddr_b(j_inc), .raddr_c(sReadAddr),
        .rdata_a(bank_j), .rdata_b(bank_j1), .rdata_c(sReadData)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (start_ok) state_next = S_CMP;
            S_CMP:      if (gt)             state_next = S_SWAP_HI;
                        else if (last_pair) state_next = S_PASS_END;
            S_SWAP_HI:  state_next = S_SWAP_LO;
            S_SWAP_LO:  state_next = last_pair ? S_PASS_END : S_CMP;
            S_PASS_END: state_next = sort_finished ? S_DONE : S_CMP;
            S_DONE:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Outputs: ALU drive, status and bank write port
    always_comb begin
        sAluA      = '0;
        sAluB      = '0;
        sSelAlu    = SELECTION'(ALU_PASS_A);
        sBusy      = 1'b0;
        sDone      = 1'b0;
        bank_we    = 1'b0;
        bank_waddr = j;
        bank_wdata = sAluResult;
        case (state)
            S_IDLE: begin
                bank_we    = load_fire;
                bank_waddr = count[ADDRWIDTH-1:0];
                bank_wdata = sLoadData;
            end
            S_CMP: begin
                sAluA   = bank_j;
                sAluB   = bank_j1;
                sSelAlu = SELECTION'(ALU_SUB);
                sBusy   = 1'b1;
            end
            S_SWAP_HI: begin
                // Old bank[j] moves up through the ALU into slot j+1.
                sAluA      = bank_j;
                sBusy      = 1'b1;
                bank_we    = 1'b1;
                bank_waddr = j_inc;
            end
            S_SWAP_LO: begin
                // Old bank[j+1] was captured in tmp during CMP.
                sAluB      = tmp;
                sSelAlu    = SELECTION'(ALU_PASS_B);
                sBusy      = 1'b1;
                bank_we    = 1'b1;
                bank_waddr = j;
            end
            S_PASS_END: sBusy = 1'b1;
            S_DONE:     sDone = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count      <= '0;
            j          <= '0;
            lim        <= '0;
            swapped    <= 1'b0;
            tmp        <= '0;
            sSwapCount <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sClear)         count <= '0;
                    else if (load_fire) count <= count + 1'b1;
                    if (start_ok) begin
                        j          <= '0;
                        lim        <= LIM_INIT;
                        swapped    <= 1'b0;
                        sSwapCount <= '0;
                    end
                end
                S_CMP: begin
                    tmp <= bank_j1;
                    if (gt)              swapped <= 1'b1;
                    else if (!last_pair) j <= j_inc;
                end
                S_SWAP_LO: begin
                    if (sSwapCount != 8'hFF) sSwapCount <= sSwapCount + 8'd1;
                    if (!last_pair) j <= j_inc;
                end
                S_PASS_END: begin
                    if (!sort_finished) begin
                        lim     <= lim - 1'b1;
                        j       <= '0;
                        swapped <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sort_sequencer.sv
module tb_alu_sort_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sLoadValid, sClear, sStart;
    logic [7:0] sLoadData;
    logic       sLoadReady, sBusy, sDone;
    logic [7:0] sSwapCount;
    logic [2:0] sReadAddr;
    logic [7:0] sReadData, sAluA, sAluB, sAluResult;
    logic [2:0] sSelAlu, dbg_state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0][7:0] din;
        logic [7:0][7:0] dout;
        int              swaps;
        int              done_at;
    } vec_t;

    vec_t tbl [3];

    always #5 clk = ~clk;

    alu_sort_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .sLoadValid(sLoadValid), .sLoadData(sLoadData), .sLoadReady(sLoadReady),
        .sClear(sClear), .sStart(sStart), .sBusy(sBusy), .sDone(sDone),
        .sSwapCount(sSwapCount), .sReadAddr(sReadAddr), .sReadData(sReadData),
        .sAluA(sAluA), .sAluB(sAluB), .sSelAlu(sSelAlu), .sAluResult(sAluResult),
        .dbg_state(dbg_state)
    );

    // Neighbouring ALU: only the codes the sequencer uses are modelled.
    always_comb begin
        case (sSelAlu)
            3'b000:  sAluResult = sAluA;
            3'b001:  sAluResult = sAluA - sAluB;
            3'b101:  sAluResult = sAluB;
            default: sAluResult = 8'h00;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: sorted result from a queue sort; swaps = inversion count;
    // passes = 1 + largest number of greater elements preceding any element.
    task automatic model(input logic [7:0][7:0] d, output logic [7:0][7:0] s,
                         output int swaps, output int done_at);
        logic [7:0] q [$];
        int inv, maxd, passes, cmps;
        inv = 0; maxd = 0; cmps = 0;
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        q.sort();
        for (int i = 0; i < 8; i++) s[i] = q[i];
        for (int k = 0; k < 8; k++) begin
            int g;
            g = 0;
            for (int i = 0; i < k; i++) if (d[i] > d[k]) g++;
            inv += g;
            if (g > maxd) maxd = g;
        end
        passes = (maxd + 1 > 7) ? 7 : maxd + 1;
        for (int p = 1; p <= passes; p++) cmps += 8 - p;
        swaps   = (inv > 255) ? 255 : inv;
        done_at = cmps + 2 * inv + passes + 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic clear_count();
        sClear = 1'b1;
        @(posedge clk);
        #1 sClear = 1'b0;
    endtask

    task automatic load_words(input logic [7:0][7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            sLoadValid = 1'b1;
            sLoadData  = w[i];
            @(posedge clk);
            #1;
        end
        sLoadValid = 1'b0;
    endtask

    task automatic read_bank(output logic [7:0][7:0] v);
        for (int i = 0; i < 8; i++) begin
            sReadAddr = 3'(i);
            #1 v[i] = sReadData;
        end
    endtask

    // Pulses start and returns the cycle (start edge = 0) in which sDone is seen.
    task automatic run_sort(output int done_at);
        sStart = 1'b1;
        @(posedge clk);
        #1 sStart = 1'b0;
        done_at = -1;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                check("busy_cycle1", sBusy, 1'b1);
                check("ready_during_sort", sLoadReady, 1'b0);
            end
            if (sDone) begin
                done_at = cyc;
                break;
            end
            @(posedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sort_and_check(input string tag, input logic [7:0][7:0] d,
                                  input logic [7:0][7:0] exp_bank,
                                  input int exp_swaps, input int exp_done);
        int              got_done;
        logic [7:0][7:0] got_bank;
        clear_count();
        load_words(d, 8);
        check({tag, "_ready_full"}, sLoadReady, 1'b0);
        run_sort(got_done);
        check({tag, "_done_cycle"}, 64'(got_done), 64'(exp_done));
        check({tag, "_swaps"}, sSwapCount, 8'(exp_swaps));
        read_bank(got_bank);
        check({tag, "_bank"}, got_bank, exp_bank);
    endtask

    initial begin
        logic [7:0]      v3 [8];
        logic [7:0][7:0] d, s, rb;
        int              sw, dn, got_done;
        logic            saw_done;

        rst_n = 1'b0; sLoadValid = 1'b0; sLoadData = '0; sClear = 1'b0;
        sStart = 1'b0; sReadAddr = '0;

        v3 = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01, 8'hFE, 8'h7F, 8'h80};
        for (int i = 0; i < 8; i++) begin
            tbl[0].din[i] = 8'(8 - i);  tbl[0].dout[i] = 8'(i + 1);
            tbl[1].din[i] = 8'(i + 1);  tbl[1].dout[i] = 8'(i + 1);
            tbl[2].din[i] = v3[i];
        end
        v3 = '{8'h00, 8'h01, 8'h7F, 8'h7F, 8'h80, 8'h80, 8'hFE, 8'hFF};
        for (int i = 0; i < 8; i++) tbl[2].dout[i] = v3[i];
        tbl[0].swaps = 28; tbl[0].done_at = 92;
        tbl[1].swaps = 0;  tbl[1].done_at = 9;
        tbl[2].swaps = 13; tbl[2].done_at = 53;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_busy", sBusy, 1'b0);
        check("rst_done", sDone, 1'b0);
        check("rst_swaps", sSwapCount, 8'h00);
        check("rst_ready", sLoadReady, 1'b1);
        read_bank(rb);
        check("rst_bank", rb, 64'h0);

        // Fixed vectors
        for (int t = 0; t < 3; t++) begin
            sort_and_check($sformatf("vec%0d", t), tbl[t].din, tbl[t].dout,
                           tbl[t].swaps, tbl[t].done_at);
        end

        // Restart without reloading: already sorted, so no swaps.
        read_bank(s);
        run_sort(got_done);
        check("restart_done_cycle", 64'(got_done), 64'd9);
        check("restart_swaps", sSwapCount, 8'h00);
        read_bank(rb);
        check("restart_bank", rb, s);
        clear_count();
        check("clear_ready", sLoadReady, 1'b1);
        d = '0; d[0] = 8'h5A;
        load_words(d, 1);
        sReadAddr = 3'd0;
        #1 check("clear_load_addr0", sReadData, 8'h5A);
        check("clear_ready_after1", sLoadReady, 1'b1);

        // Random data, some with a narrow range to force equal values.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++)
                d[i] = (r % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
            model(d, s, sw, dn);
            sort_and_check($sformatf("rand%0d", r), d, s, sw, dn);
        end

        // Start with only five words is ignored.
        clear_count();
        for (int i = 0; i < 8; i++) d[i] = 8'($urandom_range(0, 255));
        load_words(d, 5);
        sStart = 1'b1;
        @(posedge clk);
        #1 sStart = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("partial_busy", sBusy, 1'b0);
            check("partial_done", sDone, 1'b0);
        end
        @(posedge clk); #1;
        for (int i = 5; i < 8; i++) begin
            sLoadValid = 1'b1; sLoadData = d[i];
            @(posedge clk);
            #1;
            check($sformatf("partial_ready_after%0d", i + 1), sLoadReady, (i == 7) ? 1'b0 : 1'b1);
        end
        sLoadValid = 1'b0;
        model(d, s, sw, dn);
        run_sort(got_done);
        check("partial_done_cycle", 64'(got_done), 64'(dn));
        read_bank(rb);
        check("partial_bank", rb, s);

        // Reset during cycle 20 of the reverse sort.
        clear_count();
        load_words(tbl[0].din, 8);
        sStart = 1'b1;
        @(posedge clk);
        #1 sStart = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("midrst_busy", sBusy, 1'b0);
        check("midrst_state_idle", dbg_state, 3'd0);
        check("midrst_ready", sLoadReady, 1'b1);
        read_bank(rb);
        check("midrst_bank", rb, 64'h0);
        saw_done = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (sDone || sBusy) saw_done = 1'b1;
        end
        check("midrst_no_done", saw_done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
